load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Load/store unit port bundle: core request/response and memory bus.
// slave = the unit, master = core plus bus (testbench side).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_read;
  logic        bus_write;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  req_size, req_unsigned, bus_ack, bus_rdata,
    output req_ready, bus_addr, bus_wdata, bus_byte_en,
    output bus_read, bus_write, resp_valid, resp_rdata,
    output resp_error
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output req_size, req_unsigned, bus_ack, bus_rdata,
    input  req_ready, bus_addr, bus_wdata, bus_byte_en,
    input  bus_read, bus_write, resp_valid, resp_rdata,
    input  resp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, lane steering, load extension,
// bus wait timeout. Ports: clock, reset, lsu (slave of the bundle).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_write;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misal;
  logic        w_in_bus;
  logic        w_ack;
  logic        w_timeout;
  logic [7:0]  w_cnt_inc;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;

  assign w_accept = lsu.req_valid && (r_state == S_IDLE);

  assign w_misal =
    (lsu.req_size == 2'd3) ||
    ((lsu.req_size == 2'd1) && lsu.req_addr[0]) ||
    ((lsu.req_size == 2'd2) && (lsu.req_addr[1:0] != 2'b00));

  assign w_in_bus  = (r_state == S_BUS);
  assign w_ack     = w_in_bus && lsu.bus_ack;
  assign w_cnt_inc = r_cnt + 8'd1;
  // The cycle that would reach the limit is the last one; an ack
  // arriving in it still completes normally.
  assign w_timeout = w_in_bus && !lsu.bus_ack &&
                     (w_cnt_inc == 8'(TIMEOUT_CYCLES));

  assign w_shift = lsu.bus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load  = w_shift;
    w_wdata = r_wdata;
    w_be    = 4'b1111;
    unique case (r_size)
      2'd0: begin
        w_load  = r_uns ? {24'd0, w_shift[7:0]}
                        : {{24{w_shift[7]}}, w_shift[7:0]};
        w_wdata = {4{r_wdata[7:0]}};
        w_be    = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        w_load  = r_uns ? {16'd0, w_shift[15:0]}
                        : {{16{w_shift[15]}}, w_shift[15:0]};
        w_wdata = {2{r_wdata[15:0]}};
        w_be    = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_load  = w_shift;
        w_wdata = r_wdata;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_misal ? S_RESP : S_BUS;
      end
      S_BUS: begin
        if (w_ack || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= lsu.req_write;
        r_uns   <= lsu.req_unsigned;
        r_addr  <= lsu.req_addr;
        r_wdata <= lsu.req_wdata;
        r_size  <= lsu.req_size;
        r_cnt   <= 8'd0;
        if (w_misal) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end
      end
      if (w_in_bus) begin
        if (lsu.bus_ack) begin
          r_rdata <= r_write ? 32'd0 : w_load;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign lsu.req_ready   = (r_state == S_IDLE);
  assign lsu.bus_addr    = {r_addr[31:2], 2'b00};
  assign lsu.bus_wdata   = w_wdata;
  assign lsu.bus_byte_en = w_in_bus ? w_be : 4'b0000;
  assign lsu.bus_read    = w_in_bus && !r_write;
  assign lsu.bus_write   = w_in_bus && r_write;
  assign lsu.resp_valid  = (r_state == S_RESP);
  assign lsu.resp_rdata  = r_rdata;
  assign lsu.resp_error  = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed spec scenarios plus random
// accesses scored against a byte-level reference model.
module tb_load_store_unit;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  load_store_unit_if lsu();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock),
    .reset(reset),
    .lsu  (lsu)
  );

  always #5 clock = ~clock;

  int          o_lat, o_strobes;
  logic [3:0]  o_be;
  logic [31:0] o_wd, o_addr, o_rdata;
  logic        o_err, o_leak, o_dirbad, o_rdy_start;
  logic        o_valid_after, o_ready_after, o_held;

  int          e_lat, e_strobes;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_addr, e_rdata;
  logic        e_err;

  // Reference: byte-lane view of the access, no knowledge of RTL states.
  task automatic model(input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz,
                       input logic u, input logic [31:0] rd,
                       input int ackd);
    int off, n;
    longint v;
    bit mis;
    off = int'(a % 4);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz == 2'd3) || ((a % n) != 0);
    e_addr = a - off;
    e_be = 4'd0;
    e_wd = 32'd0;
    if (mis) begin
      e_lat = 1; e_strobes = 0; e_err = 1'b1; e_rdata = 32'd0;
      return;
    end
    for (int i = off; i < off + n; i++) e_be[i] = 1'b1;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    if (ackd >= 0 && ackd < T) begin
      e_lat = ackd + 2; e_strobes = ackd + 1; e_err = 1'b0;
      v = 0;
      for (int k = 0; k < n; k++)
        v += longint'(rd[8*(off+k) +: 8]) << (8*k);
      if (!u && n < 4 && v >= (longint'(1) << (8*n - 1)))
        v -= (longint'(1) << (8*n));
      e_rdata = w ? 32'd0 : v[31:0];
    end else begin
      e_lat = T + 1; e_strobes = T; e_err = 1'b1; e_rdata = 32'd0;
    end
  endtask

  // Drives one request starting at a negedge; acts as the bus with an
  // ack after ackd wait cycles (-1 = never). Ends at the negedge of the
  // idle cycle following the response.
  task automatic run(input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz,
                     input logic u, input logic [31:0] rd,
                     input int ackd);
    bit done;
    o_rdy_start = lsu.req_ready;
    lsu.req_valid = 1'b1;
    lsu.req_write = w;
    lsu.req_addr = a;
    lsu.req_wdata = wd;
    lsu.req_size = sz;
    lsu.req_unsigned = u;
    @(posedge clock);
    @(negedge clock);
    lsu.req_valid = 1'b0;
    lsu.req_write = 1'($urandom);
    lsu.req_addr = $urandom;
    lsu.req_wdata = $urandom;
    lsu.req_size = 2'($urandom);
    lsu.req_unsigned = 1'($urandom);
    o_lat = -1; o_strobes = 0; o_leak = 0; o_dirbad = 0;
    o_be = 0; o_wd = 0; o_addr = 0; o_rdata = 0; o_err = 0;
    o_valid_after = 0; o_ready_after = 0; o_held = 0;
    done = 0;
    for (int j = 1; j <= 40 && !done; j++) begin
      if (lsu.bus_read || lsu.bus_write) begin
        o_strobes++;
        o_be = lsu.bus_byte_en;
        o_wd = lsu.bus_wdata;
        o_addr = lsu.bus_addr;
        if (lsu.bus_write !== w || lsu.bus_read !== !w) o_dirbad = 1;
      end else if (lsu.bus_byte_en !== 4'd0) begin
        o_leak = 1;
      end
      if (lsu.resp_valid) begin
        o_lat = j;
        o_rdata = lsu.resp_rdata;
        o_err = lsu.resp_error;
        lsu.bus_ack = 1'b0;
        @(negedge clock);
        o_valid_after = lsu.resp_valid;
        o_ready_after = lsu.req_ready;
        o_held = (lsu.resp_rdata === o_rdata) &&
                 (lsu.resp_error === o_err);
        done = 1;
      end else begin
        lsu.bus_ack = (j == ackd + 1);
        lsu.bus_rdata = (j == ackd + 1) ? rd : $urandom;
        @(negedge clock);
      end
    end
    lsu.bus_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    checks++;
    if (lsu.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", lsu.req_ready);
    end
    checks++;
    if ({lsu.bus_read, lsu.bus_write, lsu.resp_valid,
         lsu.resp_error, lsu.bus_byte_en} !== 8'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {lsu.bus_read,
               lsu.bus_write, lsu.resp_valid, lsu.resp_error,
               lsu.bus_byte_en});
    end
    checks++;
    if ({lsu.resp_rdata, lsu.bus_addr, lsu.bus_wdata} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h exp=0", lsu.resp_rdata,
               lsu.bus_addr, lsu.bus_wdata);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load_extend;
    run(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80FF_1234, 0);
    checks++;
    if (o_lat != 2 || o_rdata !== 32'h80 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL ldbu got lat=%0d rd=%h err=%b exp 2 00000080 0",
               o_lat, o_rdata, o_err);
    end
    checks++;
    if (o_be !== 4'b1000 || o_addr !== 32'h100) begin
      failures++;
      $display("FAIL ldbu_bus got be=%b addr=%h exp 1000 100",
               o_be, o_addr);
    end
    run(1'b0, 32'h202, 32'h0, 2'd1, 1'b0, 32'h8001_0000, 0);
    checks++;
    if (o_rdata !== 32'hFFFF_8001) begin
      failures++;
      $display("FAIL ldh got=%h exp=ffff8001", o_rdata);
    end
    run(1'b0, 32'h202, 32'h0, 2'd1, 1'b1, 32'h8001_0000, 0);
    checks++;
    if (o_rdata !== 32'h0000_8001) begin
      failures++;
      $display("FAIL ldhu got=%h exp=00008001", o_rdata);
    end
  endtask

  task automatic test_store;
    run(1'b1, 32'h301, 32'h0000_00A5, 2'd0, 1'b0, 32'hFFFF_FFFF, 3);
    checks++;
    if (o_wd !== 32'hA5A5_A5A5 || o_be !== 4'b0010) begin
      failures++;
      $display("FAIL stb_bus got wd=%h be=%b exp a5a5a5a5 0010",
               o_wd, o_be);
    end
    checks++;
    if (o_strobes != 4 || o_lat != 5 || o_dirbad) begin
      failures++;
      $display("FAIL stb_hold got strobes=%0d lat=%0d dir=%b exp 4 5 0",
               o_strobes, o_lat, o_dirbad);
    end
    checks++;
    if (o_rdata !== 32'd0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL stb_resp got rd=%h err=%b exp 0 0", o_rdata, o_err);
    end
  endtask

  task automatic test_misaligned;
    run(1'b0, 32'h402, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 0);
    checks++;
    if (o_lat != 1 || o_err !== 1'b1 || o_strobes != 0 ||
        o_rdata !== 32'd0) begin
      failures++;
      $display("FAIL mis_word got lat=%0d err=%b str=%0d rd=%h exp 1 1 0 0",
               o_lat, o_err, o_strobes, o_rdata);
    end
    run(1'b0, 32'h400, 32'h0, 2'd3, 1'b0, 32'h1234_5678, 1);
    checks++;
    if (o_lat != 1 || o_err !== 1'b1 || o_strobes != 0) begin
      failures++;
      $display("FAIL mis_size3 got lat=%0d err=%b str=%0d exp 1 1 0",
               o_lat, o_err, o_strobes);
    end
  endtask

  task automatic test_timeout;
    run(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 32'h0, -1);
    checks++;
    if (o_strobes != T || o_lat != T + 1 || o_err !== 1'b1 ||
        o_rdata !== 32'd0) begin
      failures++;
      $display("FAIL timeout got str=%0d lat=%0d err=%b rd=%h exp %0d %0d 1 0",
               o_strobes, o_lat, o_err, o_rdata, T, T + 1);
    end
    run(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, T - 1);
    checks++;
    if (o_strobes != T || o_err !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL ack_wins got str=%0d err=%b rd=%h exp %0d 0 cafef00d",
               o_strobes, o_err, o_rdata, T);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 32'h600 + 32'(4*i), 32'h0, 2'd2, 1'b0,
          32'h1111_0000 + 32'(i), 0);
      checks++;
      if (o_rdy_start !== 1'b1 || o_lat != 2 ||
          o_rdata !== 32'h1111_0000 + 32'(i)) begin
        failures++;
        $display("FAIL b2b%0d got rdy=%b lat=%0d rd=%h", i, o_rdy_start,
                 o_lat, o_rdata);
      end
    end
  endtask

  task automatic test_random;
    logic w, u;
    logic [31:0] a, wd, rd;
    logic [1:0] sz;
    int ackd;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom); u = 1'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      sz = 2'($urandom_range(0, 3));
      ackd = int'($urandom_range(0, T + 1)) - 1;
      model(w, a, wd, sz, u, rd, ackd);
      run(w, a, wd, sz, u, rd, ackd);
      checks++;
      if (o_lat != e_lat || o_strobes != e_strobes) begin
        failures++;
        $display("FAIL rnd%0d_timing got lat=%0d str=%0d exp %0d %0d",
                 i, o_lat, o_strobes, e_lat, e_strobes);
      end
      checks++;
      if (o_rdata !== e_rdata || o_err !== e_err) begin
        failures++;
        $display("FAIL rnd%0d_resp got rd=%h err=%b exp %h %b",
                 i, o_rdata, o_err, e_rdata, e_err);
      end
      if (e_strobes > 0) begin
        checks++;
        if (o_be !== e_be || o_addr !== e_addr ||
            (w && o_wd !== e_wd) || o_dirbad) begin
          failures++;
          $display("FAIL rnd%0d_bus got be=%b a=%h wd=%h dir=%b exp %b %h %h",
                   i, o_be, o_addr, o_wd, o_dirbad, e_be, e_addr, e_wd);
        end
      end
      checks++;
      if (o_leak || o_valid_after || !o_ready_after || !o_held ||
          !o_rdy_start) begin
        failures++;
        $display("FAIL rnd%0d_proto got leak=%b va=%b ra=%b held=%b rs=%b",
                 i, o_leak, o_valid_after, o_ready_after, o_held,
                 o_rdy_start);
      end
    end
  endtask

  task automatic test_reset_mid_bus;
    bit seen;
    lsu.req_valid = 1'b1;
    lsu.req_write = 1'b0;
    lsu.req_addr = 32'h700;
    lsu.req_size = 2'd2;
    lsu.req_unsigned = 1'b0;
    @(posedge clock);
    @(negedge clock);
    lsu.req_valid = 1'b0;
    checks++;
    if (lsu.bus_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got bus_read=%b exp=1", lsu.bus_read);
    end
    #2;
    reset = 1'b1;
    lsu.bus_ack = 1'b1;
    #1;
    checks++;
    if (lsu.bus_read !== 1'b0 || lsu.req_ready !== 1'b1 ||
        lsu.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got rd=%b rdy=%b rv=%b exp 0 1 0",
               lsu.bus_read, lsu.req_ready, lsu.resp_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    lsu.bus_ack = 1'b0;
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      if (lsu.resp_valid) seen = 1;
      @(negedge clock);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_noresp got resp_valid=1 exp=0");
    end
    model(1'b0, 32'h705, 32'h0, 2'd0, 1'b0, 32'h0000_F700, 1);
    run(1'b0, 32'h705, 32'h0, 2'd0, 1'b0, 32'h0000_F700, 1);
    checks++;
    if (o_rdata !== e_rdata || o_lat != e_lat || o_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_after got rd=%h lat=%0d exp %h %0d",
               o_rdata, o_lat, e_rdata, e_lat);
    end
  endtask

  initial begin
    lsu.req_valid = 1'b0;
    lsu.req_write = 1'b0;
    lsu.req_addr = 32'd0;
    lsu.req_wdata = 32'd0;
    lsu.req_size = 2'd0;
    lsu.req_unsigned = 1'b0;
    lsu.bus_ack = 1'b0;
    lsu.bus_rdata = 32'd0;
    #1;
    test_reset();
    test_load_extend();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
